// File: rtl/bcd2bin.sv
// -----------------------------------------------------------------------------
// bcd2bin -- sequential two-digit BCD to binary converter.
//
// Converts a packed two-digit BCD number {bcd_h, bcd_l} (0..99) into a 7-bit
// binary value using reverse double-dabble: the {BCD, binary} pair is shifted
// right one bit per cycle, and any BCD digit that reaches 8 or more after the
// shift has 3 subtracted from it. Seven shifts move the whole value into the
// binary register.
//
// Timing: start is sampled in IDLE at edge E0. Shifts happen at E1..E7, and
// the result is published with a one-cycle done pulse at E8. start is ignored
// while busy. If start is held high, the next conversion begins at E9.
//
// Ports:
//   clk    in   clock, rising-edge active
//   rst    in   asynchronous reset, active low
//   start  in   conversion request, level-sampled in IDLE
//   bcd_h  in   [3:0] tens digit
//   bcd_l  in   [3:0] units digit
//   busy   out  high while a conversion is in progress (E0..E8)
//   done   out  one-cycle completion pulse
//   dout   out  [6:0] binary result, held between done pulses
//   err    out  invalid-digit flag, held between done pulses
//
// Configuration:
//   BCD2BIN_ERR_EN  when defined, digits above 9 at E0 are flagged. At E8 the
//                   flagged conversion drives err=1 and dout=0. When undefined,
//                   err is tied low and out-of-range digits produce the
//                   unchecked algorithm result.
// -----------------------------------------------------------------------------
module bcd2bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_l,
  output logic       busy,
  output logic       done,
  output logic [6:0] dout,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [6:0]  bin_q, bin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [6:0]  dout_q, dout_d;

`ifdef BCD2BIN_ERR_EN
  logic        errFlag_q, errFlag_d;
  logic        err_q, err_d;
`endif

  logic [14:0] shifted;
  logic [3:0]  hiAdj;
  logic [3:0]  loAdj;

  // One reverse double-dabble step. A shifted digit of 8+ came from a bit
  // worth 10 in the digit above it, which the shift turned into 8; subtracting
  // 3 fixes it to 5. The result is never above 12, so it fits in 4 bits.
  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    hiAdj   = shifted[14:11];
    loAdj   = shifted[10:7];
    if (hiAdj >= 4'd8) begin
      hiAdj = hiAdj - 4'd3;
    end
    if (loAdj >= 4'd8) begin
      loAdj = loAdj - 4'd3;
    end
  end

  // Next-state logic. The counter counts completed shifts, so the seventh
  // shift (cnt_q == 6) is also the one that moves the FSM to DONE.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
`ifdef BCD2BIN_ERR_EN
    errFlag_d = errFlag_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {bcd_h, bcd_l};
          bin_d   = 7'd0;
          cnt_d   = 3'd0;
`ifdef BCD2BIN_ERR_EN
          errFlag_d = (bcd_h > 4'd9) || (bcd_l > 4'd9);
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {hiAdj, loAdj};
        bin_d = shifted[6:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef BCD2BIN_ERR_EN
        dout_d = errFlag_q ? 7'd0 : bin_q;
        err_d  = errFlag_q;
`else
        dout_d = bin_q;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any conversion in flight, so no
  // done pulse can follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= 8'd0;
      bin_q   <= 7'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      dout_q  <= 7'd0;
`ifdef BCD2BIN_ERR_EN
      errFlag_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
`ifdef BCD2BIN_ERR_EN
      errFlag_q <= errFlag_d;
      err_q     <= err_d;
`endif
    end
  end

  // busy drops at E8 while done rises, so the two never overlap.
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dout = dout_q;

`ifdef BCD2BIN_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin -- self-checking bench for bcd2bin.
//
// Stimulus tasks queue the expected {err, dout} for every conversion they
// start. A separate monitor pops one entry for each done pulse and compares
// it. Latency, busy width, reset behaviour and held outputs are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_bcd2bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] bcd_h;
  logic [3:0] bcd_l;
  logic       busy;
  logic       done;
  logic [6:0] dout;
  logic       err;

  int numChecks = 0;
  int numErrors = 0;

  logic [7:0] expQ[$];

  bcd2bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd_h (bcd_h),
    .bcd_l (bcd_l),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .err   (err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison helper shared by stimulus and monitor.
  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks++;
    if (actual != expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, and
  // busy must be low whenever done is high.
  always @(negedge clk) begin
    if (rst && done) begin
      if (expQ.size() == 0) begin
        numChecks++;
        numErrors++;
        $display("[TB] FAIL unexpectedDone: got done=1 with dout=0x%0h, expected no done at %0t",
                 dout, $time);
      end else begin
        logic [7:0] exp;
        exp = expQ.pop_front();
        checkOutput("dout", int'(dout), int'(exp[6:0]));
        checkOutput("err", int'(err), int'(exp[7]));
        checkOutput("busyWithDone", int'(busy), 0);
      end
    end
  end

  // Start one conversion, queue its expected result and wait for done. start
  // is raised before the sampling edge E0. Afterwards it is either dropped or
  // left high for back-to-back runs. The task returns just after E8.
  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] l,
                               input logic [6:0] expDout, input logic expErr,
                               input bit holdStart);
    int lat;
    int busyCount;
    bcd_h = h;
    bcd_l = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back({expErr, expDout});
    if (!holdStart) start = 1'b0;
    busyCount = busy ? 1 : 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) busyCount++;
    end
    checkOutput("latency", lat, 8);
    checkOutput("busyCycles", busyCount, 8);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst   = 1'b0;
    start = 1'b0;
    bcd_h = 4'd0;
    bcd_l = 4'd0;
    #1;
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetDout", int'(dout), 0);
    checkOutput("resetErr", int'(err), 0);
    idleCycles(3);
    rst = 1'b1;
    idleCycles(2);

    $display("[TB] basic conversions");
    applyStimulus(4'd4, 4'd2, 7'h2A, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("doutHeld", int'(dout), 'h2A);
    applyStimulus(4'd9, 4'd9, 7'h63, 1'b0, 1'b0);
    applyStimulus(4'd0, 4'd0, 7'h00, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] out-of-range digit");
`ifdef BCD2BIN_ERR_EN
    applyStimulus(4'hA, 4'd3, 7'h00, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("errHeld", int'(err), 1);
`else
    applyStimulus(4'hA, 4'd3, 7'h67, 1'b0, 1'b0);
    idleCycles(2);
`endif
    applyStimulus(4'd1, 4'd5, 7'h0F, 1'b0, 1'b0);
    idleCycles(2);

    // A start pulse with new digits in the middle of a conversion must be ignored.
    $display("[TB] start during busy");
    bcd_h = 4'd3;
    bcd_l = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back({1'b0, 7'h25});
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    bcd_h = 4'd5;
    bcd_l = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 4;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    checkOutput("latencyIgnoredStart", lat, 8);
    idleCycles(12);

    // Reset in the middle of a conversion must abort it with no done pulse.
    $display("[TB] reset mid-conversion");
    bcd_h = 4'd8;
    bcd_l = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(posedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortDout", int'(dout), 0);
    checkOutput("abortErr", int'(err), 0);
    idleCycles(2);
    rst = 1'b1;
    idleCycles(12);
    applyStimulus(4'd1, 4'd2, 7'h0C, 1'b0, 1'b0);
    idleCycles(2);

    // Back-to-back sweep with start held high. Each task call checks that the
    // next conversion starts at E9, so done repeats every 9 cycles.
    $display("[TB] full sweep with start held");
    for (int h = 0; h < 10; h++) begin
      for (int l = 0; l < 10; l++) begin
        applyStimulus(4'(h), 4'(l), 7'(10 * h + l), 1'b0, 1'b1);
      end
    end
    start = 1'b0;
    idleCycles(12);

    checkOutput("pendingExpected", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule
